caf_corr_scheduler: RTL and testbench
=====================================

// Module: caf_corr_scheduler
// PURPOSE
//  Sequences the correlate phase of the CAF engine once the capture buffer is full.
//  Sweeps every capture start offset (shift) and, per shift, streams paired read
//  addresses to the reference and capture buffers with first/last beat markers.
//  Then waits for the per-frequency accumulator bank to hand back that shift's result.
//  Sits between the capture FSM (issues start) and the buffer read ports / accumulators.
// PARAMETERS
//  REF_LEN         16  reference buffer length in samples (>=2)
//  CAP_LEN         64  capture buffer length in samples (>=REF_LEN)
//  REF_INDEX_BITS  4   width of reference read address, >= clog2(REF_LEN)
//  CAP_INDEX_BITS  6   width of capture read address / shift index, >= clog2(CAP_LEN)
// PORTS
//  clk          in   1               clock, all logic on rising edge
//  rst_n        in   1               asynchronous active-low reset
//  start        in   1               1-cycle pulse: capture complete, begin sweep
//  abort        in   1               level; forces return to IDLE next edge
//  busy         out  1               high from start accept until DONE state exits
//  done         out  1               1-cycle pulse after last shift result accepted
//  rd_valid     out  1               read address pair valid
//  rd_ready     in   1               both buffer read ports ready (ANDed upstream)
//  ref_raddr    out  REF_INDEX_BITS  reference read address k
//  cap_raddr    out  CAP_INDEX_BITS  capture read address s+k
//  rd_first     out  1               beat is k==0 (accumulators clear)
//  rd_last      out  1               beat is k==REF_LEN-1 (accumulators close)
//  shift_idx    out  CAP_INDEX_BITS  current shift s, stable through WAIT_ACC
//  acc_valid    in   1               accumulator bank result for shift_idx ready
//  acc_ready    out  1               scheduler accepts result (high only in WAIT_ACC)
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, k=0, s=0; takes effect immediately, mid-sweep too.
//  States: IDLE -> ISSUE -> WAIT_ACC -> (ISSUE | DONE) -> IDLE.
//  IDLE: start=1 -> ISSUE next cycle, s=0, k=0, busy=1. Otherwise hold.
//  ISSUE: rd_valid=1; ref_raddr=k, cap_raddr=s+k (sum never exceeds CAP_LEN-1).
//   - rd_valid & rd_ready: beat accepted; k increments. Else addresses/markers held stable.
//   - rd_valid never drops without a handshake (except abort).
//   - Accepted beat with k==REF_LEN-1: k<=0, rd_valid<=0, state WAIT_ACC.
//   - Throughput: one beat per cycle while rd_ready=1; first beat one cycle after start.
//  WAIT_ACC: acc_ready=1, rd_valid=0.
//   - acc_valid & acc_ready: s==CAP_LEN-REF_LEN -> DONE; else s<=s+1, ISSUE.
//   - acc_valid arriving in ISSUE is not acknowledged (acc_ready=0); it stays pending.
//  DONE: done=1 for exactly one cycle, busy<=0, state IDLE next cycle.
//  Shift count = CAP_LEN-REF_LEN+1; CAP_LEN==REF_LEN gives a single shift s=0.
//  start while busy: ignored, no restart, no error. start coincident with DONE: ignored.
//  abort in any non-IDLE state: next edge IDLE, rd_valid=0, acc_ready=0, busy=0, no done.
//   - abort has priority over start and over any handshake in the same cycle.
//  Counters never wrap: k bounded by REF_LEN-1, s bounded by CAP_LEN-REF_LEN.
// TESTING
//  1. REF_LEN=4, CAP_LEN=6, rd_ready=1, acc_valid 2 cycles after rd_last
//     -> 3 shifts, 12 beats, cap_raddr 0-3,1-4,2-5; done pulses once.
//  2. rd_ready toggled randomly 50% -> addresses/markers stable while stalled;
//     beat sequence identical to test 1.
//  3. CAP_LEN=REF_LEN=4 -> single shift s=0, beats 0..3, rd_first on k=0,
//     rd_last on k=3, done once.
//  4. start re-pulsed mid-ISSUE and in DONE cycle -> ignored; single done; shift order unchanged.
//  5. abort during shift 1 beat 2 -> next cycle IDLE, rd_valid=0, busy=0;
//     new start restarts at s=0,k=0.
//  6. rst_n asserted mid-WAIT_ACC -> outputs 0 asynchronously; acc_valid held high
//     after release is not acknowledged.

Source files
------------

// File: rtl/caf_corr_scheduler.sv
// Correlate-phase sequencer for the CAF engine: sweeps every capture shift and streams
// paired reference/capture read addresses, then waits for the accumulator bank per shift.
module caf_corr_scheduler #(
    parameter int REF_LEN        = 16,
    parameter int CAP_LEN        = 64,
    parameter int REF_INDEX_BITS = 4,
    parameter int CAP_INDEX_BITS = 6
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      abort,
    output logic                      busy,
    output logic                      done,
    output logic                      rd_valid,
    input  logic                      rd_ready,
    output logic [REF_INDEX_BITS-1:0] ref_raddr,
    output logic [CAP_INDEX_BITS-1:0] cap_raddr,
    output logic                      rd_first,
    output logic                      rd_last,
    output logic [CAP_INDEX_BITS-1:0] shift_idx,
    input  logic                      acc_valid,
    output logic                      acc_ready
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_ACC = 2'd2,
        DONE     = 2'd3
    } state_t;

    localparam logic [REF_INDEX_BITS-1:0] K_LAST = REF_INDEX_BITS'(REF_LEN - 1);
    localparam logic [CAP_INDEX_BITS-1:0] S_LAST = CAP_INDEX_BITS'(CAP_LEN - REF_LEN);

    state_t                      state, state_nxt;
    logic [REF_INDEX_BITS-1:0]   k, k_nxt;
    logic [CAP_INDEX_BITS-1:0]   s, s_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            k     <= '0;
            s     <= '0;
        end else begin
            state <= state_nxt;
            k     <= k_nxt;
            s     <= s_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        k_nxt     = k;
        s_nxt     = s;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = ISSUE;
                    k_nxt     = '0;
                    s_nxt     = '0;
                end
            end
            ISSUE: begin
                if (rd_ready) begin
                    if (k == K_LAST) begin
                        k_nxt     = '0;
                        state_nxt = WAIT_ACC;
                    end else begin
                        k_nxt = k + 1'b1;
                    end
                end
            end
            WAIT_ACC: begin
                if (acc_valid) begin
                    if (s == S_LAST) begin
                        state_nxt = DONE;
                    end else begin
                        s_nxt     = s + 1'b1;
                        state_nxt = ISSUE;
                    end
                end
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // abort wins over start and over any handshake presented in the same cycle
        if (abort) begin
            state_nxt = IDLE;
            k_nxt     = '0;
            s_nxt     = '0;
        end
    end

    always_comb begin
        busy      = (state != IDLE);
        done      = (state == DONE);
        rd_valid  = (state == ISSUE);
        acc_ready = (state == WAIT_ACC);
        ref_raddr = k;
        cap_raddr = s + CAP_INDEX_BITS'(k);
        rd_first  = rd_valid && (k == '0);
        rd_last   = rd_valid && (k == K_LAST);
        shift_idx = s;
    end

endmodule

// File: tb/tb_caf_corr_scheduler.sv
// Randomized bench for caf_corr_scheduler: two instances (REF 4/CAP 6 and REF 4/CAP 4)
// checked cycle by cycle against a queue of expected beats built from the sweep rules.
module tb_caf_corr_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, start, abort, rd_ready, acc_valid, sel;

    logic       a_busy, a_done, a_rd_valid, a_rd_first, a_rd_last, a_acc_ready;
    logic [3:0] a_ref_raddr;
    logic [5:0] a_cap_raddr, a_shift_idx;
    logic       b_busy, b_done, b_rd_valid, b_rd_first, b_rd_last, b_acc_ready;
    logic [3:0] b_ref_raddr;
    logic [5:0] b_cap_raddr, b_shift_idx;

    caf_corr_scheduler #(.REF_LEN(4), .CAP_LEN(6), .REF_INDEX_BITS(4), .CAP_INDEX_BITS(6)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .busy(a_busy), .done(a_done),
        .rd_valid(a_rd_valid), .rd_ready(rd_ready), .ref_raddr(a_ref_raddr), .cap_raddr(a_cap_raddr),
        .rd_first(a_rd_first), .rd_last(a_rd_last), .shift_idx(a_shift_idx),
        .acc_valid(acc_valid), .acc_ready(a_acc_ready)
    );

    caf_corr_scheduler #(.REF_LEN(4), .CAP_LEN(4), .REF_INDEX_BITS(4), .CAP_INDEX_BITS(6)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .busy(b_busy), .done(b_done),
        .rd_valid(b_rd_valid), .rd_ready(rd_ready), .ref_raddr(b_ref_raddr), .cap_raddr(b_cap_raddr),
        .rd_first(b_rd_first), .rd_last(b_rd_last), .shift_idx(b_shift_idx),
        .acc_valid(acc_valid), .acc_ready(b_acc_ready)
    );

    logic       o_busy, o_done, o_rd_valid, o_rd_first, o_rd_last, o_acc_ready;
    logic [3:0] o_ref_raddr;
    logic [5:0] o_cap_raddr, o_shift_idx;
    assign o_busy      = sel ? b_busy      : a_busy;
    assign o_done      = sel ? b_done      : a_done;
    assign o_rd_valid  = sel ? b_rd_valid  : a_rd_valid;
    assign o_rd_first  = sel ? b_rd_first  : a_rd_first;
    assign o_rd_last   = sel ? b_rd_last   : a_rd_last;
    assign o_acc_ready = sel ? b_acc_ready : a_acc_ready;
    assign o_ref_raddr = sel ? b_ref_raddr : a_ref_raddr;
    assign o_cap_raddr = sel ? b_cap_raddr : a_cap_raddr;
    assign o_shift_idx = sel ? b_shift_idx : a_shift_idx;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int k;
        int c;
        bit f;
        bit l;
        int s;
    } beat_t;
    beat_t q[$];

    task automatic apply_reset;
        rst_n     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        rd_ready  = 1'b0;
        acc_valid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    // Expected behaviour: beats (k, s+k) for every shift s in order, one result per shift,
    // a single done after the last result; stalls repeat the same beat.
    task automatic run_sweep(input int rl, input int cl, input bit rnd, input bit restart,
                             input bit do_abort);
        int    phase    = 0;
        int    phase_n  = 0;
        int    wcnt     = 0;
        int    cyc      = 0;
        int    dones    = 0;
        int    cur_s    = 0;
        bit    launched = 1'b0;
        bit    aborted  = 1'b0;
        beat_t h;
        logic [3:0] want_ctl;
        logic [16:0] want_beat;
        q.delete();
        for (int s = 0; s <= cl - rl; s++)
            for (int k = 0; k < rl; k++)
                q.push_back('{k: k, c: s + k, f: (k == 0), l: (k == rl - 1), s: s});
        forever begin
            @(negedge clk);
            cyc++;
            want_ctl = {phase != 0, phase == 3, phase == 1, phase == 2};
            total++;
            if ({o_busy, o_done, o_rd_valid, o_acc_ready} !== want_ctl) begin
                bad++;
                $display("FAIL ctl cyc=%0d busy/done/rd_valid/acc_ready got=%b want=%b",
                         cyc, {o_busy, o_done, o_rd_valid, o_acc_ready}, want_ctl);
            end
            if (o_done === 1'b1) dones++;
            if (phase == 1) begin
                h = q[0];
                want_beat = {4'(h.k), 6'(h.c), h.f, h.l, 6'(h.s)};
                total++;
                if ({o_ref_raddr, o_cap_raddr, o_rd_first, o_rd_last, o_shift_idx} !== want_beat) begin
                    bad++;
                    $display("FAIL beat cyc=%0d ref/cap/first/last/shift got=%0d/%0d/%b/%b/%0d want=%0d/%0d/%b/%b/%0d",
                             cyc, o_ref_raddr, o_cap_raddr, o_rd_first, o_rd_last, o_shift_idx,
                             h.k, h.c, h.f, h.l, h.s);
                end
            end
            if (phase == 2) begin
                total++;
                if (o_shift_idx !== 6'(cur_s)) begin
                    bad++;
                    $display("FAIL shift_hold cyc=%0d got=%0d want=%0d", cyc, o_shift_idx, cur_s);
                end
            end
            start     = 1'b0;
            abort     = 1'b0;
            rd_ready  = 1'b0;
            acc_valid = 1'b0;
            phase_n   = phase;
            case (phase)
                0: begin
                    start    = 1'b1;
                    launched = 1'b1;
                    phase_n  = 1;
                end
                1: begin
                    rd_ready  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                    acc_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
                    if (restart && h.s == 0 && h.k == 1) start = 1'b1;
                    if (do_abort && h.s == 1 && h.k == 2) begin
                        abort    = 1'b1;
                        rd_ready = 1'b1;
                        aborted  = 1'b1;
                        phase_n  = 0;
                    end else if (rd_ready) begin
                        void'(q.pop_front());
                        if (h.l) begin
                            phase_n = 2;
                            cur_s   = h.s;
                            wcnt    = rnd ? $urandom_range(0, 3) : 1;
                        end
                    end
                end
                2: begin
                    if (wcnt == 0) begin
                        acc_valid = 1'b1;
                        phase_n   = (q.size() == 0) ? 3 : 1;
                    end else begin
                        wcnt--;
                    end
                end
                default: begin
                    if (restart) start = 1'b1;
                    phase_n = 0;
                end
            endcase
            phase = phase_n;
            if (phase == 0 && launched) break;
            if (cyc > 2000) begin
                bad++;
                $display("FAIL sweep_timeout cyc=%0d phase=%0d want=finish", cyc, phase);
                break;
            end
        end
        @(negedge clk);
        total++;
        if ({o_busy, o_done, o_rd_valid, o_acc_ready} !== 4'b0000) begin
            bad++;
            $display("FAIL idle_after busy/done/rd_valid/acc_ready got=%b want=0000",
                     {o_busy, o_done, o_rd_valid, o_acc_ready});
        end
        start = 1'b0; abort = 1'b0; rd_ready = 1'b0; acc_valid = 1'b0;
        total++;
        if (dones !== (aborted ? 0 : 1)) begin
            bad++;
            $display("FAIL done_count got=%0d want=%0d", dones, aborted ? 0 : 1);
        end
        if (!aborted) begin
            total++;
            if (q.size() !== 0) begin
                bad++;
                $display("FAIL beats_left got=%0d want=0", q.size());
            end
        end
    endtask

    task automatic test_reset;
        apply_reset();
        for (int i = 0; i < 2; i++) begin
            sel = i[0];
            #1;
            total++;
            if ({o_busy, o_done, o_rd_valid, o_acc_ready, o_rd_first, o_rd_last,
                 o_ref_raddr, o_cap_raddr, o_shift_idx} !== 22'd0) begin
                bad++;
                $display("FAIL reset_state inst=%0d got=%b want=0", i,
                         {o_busy, o_done, o_rd_valid, o_acc_ready, o_rd_first, o_rd_last,
                          o_ref_raddr, o_cap_raddr, o_shift_idx});
            end
        end
    endtask

    task automatic test_basic;
        sel = 1'b0; apply_reset();
        run_sweep(4, 6, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_stall;
        sel = 1'b0; apply_reset();
        for (int i = 0; i < 3; i++) run_sweep(4, 6, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_single_shift;
        sel = 1'b1; apply_reset();
        run_sweep(4, 4, 1'b0, 1'b0, 1'b0);
        run_sweep(4, 4, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_restart_ignored;
        sel = 1'b0; apply_reset();
        run_sweep(4, 6, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_abort;
        sel = 1'b0; apply_reset();
        run_sweep(4, 6, 1'b1, 1'b0, 1'b1);
        run_sweep(4, 6, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_wait_acc;
        bit found = 1'b0;
        sel = 1'b0; apply_reset();
        @(negedge clk);
        start = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            start    = 1'b0;
            rd_ready = 1'b1;
            if (o_acc_ready === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL reach_wait_acc got=acc_ready_never want=acc_ready_high");
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({o_busy, o_done, o_rd_valid, o_acc_ready, o_rd_first, o_rd_last,
             o_ref_raddr, o_cap_raddr, o_shift_idx} !== 22'd0) begin
            bad++;
            $display("FAIL async_reset got=%b want=0",
                     {o_busy, o_done, o_rd_valid, o_acc_ready, o_rd_first, o_rd_last,
                      o_ref_raddr, o_cap_raddr, o_shift_idx});
        end
        @(negedge clk);
        acc_valid = 1'b1;
        rd_ready  = 1'b1;
        #2 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if ({o_busy, o_done, o_rd_valid, o_acc_ready} !== 4'b0000) begin
                bad++;
                $display("FAIL post_reset_acc cyc=%0d got=%b want=0000", i,
                         {o_busy, o_done, o_rd_valid, o_acc_ready});
            end
        end
        acc_valid = 1'b0;
        rd_ready  = 1'b0;
    endtask

    initial begin
        sel = 1'b0;
        test_reset();
        test_basic();
        test_stall();
        test_single_shift();
        test_restart_ignored();
        test_abort();
        test_reset_wait_acc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
